// File: rtl/clk_pkg.sv
// Shared definitions for the clock time-set controller: register addresses,
// field limits, FSM state encoding and the write-command payload.
package clk_pkg;

    localparam int unsigned DATA_W        = 6;
    localparam int unsigned ADDR_W        = 2;
    localparam int unsigned MIN_SEC_MAX   = 59;
    localparam int unsigned HOURS_MAX_DEF = 23;

    localparam logic [ADDR_W-1:0] ADDR_SEC = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_MIN = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_HR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        WR_HR,
        WR_MIN,
        WR_SEC
    } state_t;

    // One write strobe towards the clock core
    typedef struct packed {
        logic              load;
        logic [ADDR_W-1:0] addrs;
        logic [DATA_W-1:0] data;
    } wr_cmd_t;

    function automatic logic is_edit(input state_t s);
        return (s == EDIT_HR) || (s == EDIT_MIN) || (s == EDIT_SEC);
    endfunction

endpackage

// File: rtl/clk_set_ctrl_if.sv
// Button inputs and clock-core write/status outputs of clk_set_ctrl.
interface clk_set_ctrl_if;
    import clk_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic              btn_set;
    logic              load;
    logic [ADDR_W-1:0] addrs;
    logic [DATA_W-1:0] data_in;
    logic              edit_active;
    logic [ADDR_W-1:0] edit_field;

    // Controller side
    modport master (
        input  btn_mode, btn_inc, btn_set,
        output load, addrs, data_in, edit_active, edit_field
    );

    // Button source / clock-core side
    modport slave (
        output btn_mode, btn_inc, btn_set,
        input  load, addrs, data_in, edit_active, edit_field
    );

endinterface

// File: rtl/clk_set_field.sv
// One editable time field: 6-bit register with synchronous clear and
// wrap-to-zero increment at a configurable limit.
module clk_set_field
    import clk_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [DATA_W-1:0] limit,
    output logic [DATA_W-1:0] value
);

    // Clear wins over increment; anything at or above the limit wraps to 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value >= limit) ? '0 : value + DATA_W'(1);
        end
    end

endmodule

// File: rtl/clk_set_ctrl.sv
// Time-set controller: button-driven editing of hh/mm/ss followed by a
// three-cycle commit (hours, minutes, seconds) to the clock core.
// Optional feature: define CLK_SET_TIMEOUT_EN to abandon an idle edit
// session after TIMEOUT_CYCLES cycles without writing anything.
module clk_set_ctrl
    import clk_pkg::*;
#(
    parameter int unsigned HOURS_MAX      = HOURS_MAX_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic           clk,
    input  logic           reset,
    clk_set_ctrl_if.master bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t            state;
    state_t            next_state;
    logic              any_btn;
    logic              timeout_hit;
    logic              clr_fields;
    logic              inc_hr;
    logic              inc_min;
    logic              inc_sec;
    logic [DATA_W-1:0] hr_val;
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] sec_val;
    wr_cmd_t           wr_next;
    logic [ADDR_W-1:0] field_next;

    assign any_btn = bus.btn_mode | bus.btn_inc | bus.btn_set;

`ifdef CLK_SET_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = is_edit(state) && !any_btn && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter: restarts on any activity, runs only while editing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (any_btn || (next_state != state) || !is_edit(state)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, field controls and next output values; set > mode > inc
    always_comb begin
        next_state = state;
        clr_fields = 1'b0;
        inc_hr     = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
        wr_next    = '0;
        field_next = ADDR_SEC;

        case (state)
            IDLE: begin
                if (bus.btn_mode) begin
                    next_state = EDIT_HR;
                    clr_fields = 1'b1;
                end
            end
            EDIT_HR: begin
                if (bus.btn_set)       next_state = WR_HR;
                else if (bus.btn_mode) next_state = EDIT_MIN;
                else                   inc_hr     = bus.btn_inc;
            end
            EDIT_MIN: begin
                if (bus.btn_set)       next_state = WR_HR;
                else if (bus.btn_mode) next_state = EDIT_SEC;
                else                   inc_min    = bus.btn_inc;
            end
            EDIT_SEC: begin
                if (bus.btn_set)       next_state = WR_HR;
                else if (bus.btn_mode) next_state = EDIT_HR;
                else                   inc_sec    = bus.btn_inc;
            end
            WR_HR:   next_state = WR_MIN;
            WR_MIN:  next_state = WR_SEC;
            WR_SEC:  next_state = IDLE;
            default: next_state = IDLE;
        endcase

        if (timeout_hit) begin
            next_state = IDLE;
        end

        case (next_state)
            WR_HR:    wr_next = '{load: 1'b1, addrs: ADDR_HR,  data: hr_val};
            WR_MIN:   wr_next = '{load: 1'b1, addrs: ADDR_MIN, data: min_val};
            WR_SEC:   wr_next = '{load: 1'b1, addrs: ADDR_SEC, data: sec_val};
            EDIT_HR:  field_next = ADDR_HR;
            EDIT_MIN: field_next = ADDR_MIN;
            default:  field_next = ADDR_SEC;
        endcase
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.load        <= 1'b0;
            bus.addrs       <= ADDR_SEC;
            bus.data_in     <= '0;
            bus.edit_active <= 1'b0;
            bus.edit_field  <= ADDR_SEC;
        end else begin
            bus.load        <= wr_next.load;
            bus.addrs       <= wr_next.addrs;
            bus.data_in     <= wr_next.data;
            bus.edit_active <= is_edit(next_state);
            bus.edit_field  <= field_next;
        end
    end

    clk_set_field u_hr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_fields),
        .inc   (inc_hr),
        .limit (DATA_W'(HOURS_MAX)),
        .value (hr_val)
    );

    clk_set_field u_min (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_fields),
        .inc   (inc_min),
        .limit (DATA_W'(MIN_SEC_MAX)),
        .value (min_val)
    );

    clk_set_field u_sec (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_fields),
        .inc   (inc_sec),
        .limit (DATA_W'(MIN_SEC_MAX)),
        .value (sec_val)
    );

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Directed bench for clk_set_ctrl (HOURS_MAX=23, TIMEOUT_CYCLES=16).
module tb_clk_set_ctrl;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic load_seen;

    clk_set_ctrl_if bus ();

    clk_set_ctrl #(
        .HOURS_MAX      (23),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold the given buttons for one clock edge, then release
    task automatic step(input logic m, input logic i, input logic s);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_set  = s;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_set  = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Called right after the edge that sampled btn_set
    task automatic chk_commit(input string tag, input int h, input int m, input int s);
        chk({tag, "_hr_load"}, 32'(bus.load), 32'd1);
        chk({tag, "_hr_addr"}, 32'(bus.addrs), 32'd2);
        chk({tag, "_hr_data"}, 32'(bus.data_in), 32'(h));
        chk({tag, "_hr_edit"}, 32'(bus.edit_active), 32'd0);
        nop(1);
        chk({tag, "_min_load"}, 32'(bus.load), 32'd1);
        chk({tag, "_min_addr"}, 32'(bus.addrs), 32'd1);
        chk({tag, "_min_data"}, 32'(bus.data_in), 32'(m));
        nop(1);
        chk({tag, "_sec_load"}, 32'(bus.load), 32'd1);
        chk({tag, "_sec_addr"}, 32'(bus.addrs), 32'd0);
        chk({tag, "_sec_data"}, 32'(bus.data_in), 32'(s));
        nop(1);
        chk({tag, "_end_load"}, 32'(bus.load), 32'd0);
        chk({tag, "_end_edit"}, 32'(bus.edit_active), 32'd0);
        chk({tag, "_end_data"}, 32'(bus.data_in), 32'd0);
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_set  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load",  32'(bus.load), 32'd0);
        chk("rst_addrs", 32'(bus.addrs), 32'd0);
        chk("rst_data",  32'(bus.data_in), 32'd0);
        chk("rst_edit",  32'(bus.edit_active), 32'd0);
        chk("rst_field", 32'(bus.edit_field), 32'd0);
        reset = 1'b1;

        // inc/set ignored in IDLE
        step(1'b0, 1'b1, 1'b0);
        chk("idle_inc_load", 32'(bus.load), 32'd0);
        chk("idle_inc_edit", 32'(bus.edit_active), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("idle_set_load", 32'(bus.load), 32'd0);
        chk("idle_set_edit", 32'(bus.edit_active), 32'd0);
        nop(1);
        chk("idle_after_load", 32'(bus.load), 32'd0);

        // 5 hours, 59 minutes
        step(1'b1, 1'b0, 1'b0);
        chk("enter_edit",  32'(bus.edit_active), 32'd1);
        chk("enter_field", 32'(bus.edit_field), 32'd2);
        chk("enter_load",  32'(bus.load), 32'd0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("min_field", 32'(bus.edit_field), 32'd1);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        chk("min_no_load", 32'(bus.load), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk_commit("c_5_59_0", 5, 59, 0);

        // Hour maximum and wrap; fields cleared on re-entry
        step(1'b1, 1'b0, 1'b0);
        repeat (23) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_commit("c_hr23", 23, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        repeat (24) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_commit("c_hr_wrap", 0, 0, 0);

        // Priority mode > inc, field rotation, set > mode
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("prio_mode_field", 32'(bus.edit_field), 32'd1);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("sec_field", 32'(bus.edit_field), 32'd0);
        chk("sec_edit",  32'(bus.edit_active), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rot_hr_field", 32'(bus.edit_field), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_commit("c_prio", 2, 2, 1);

        // set + inc together in EDIT_MIN: minute untouched
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk_commit("c_set_inc", 0, 3, 0);

        // Buttons during WR_* ignored
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("wr_ign_hr_data", 32'(bus.data_in), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("wr_ign_min_addr", 32'(bus.addrs), 32'd1);
        chk("wr_ign_min_data", 32'(bus.data_in), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("wr_ign_sec_load", 32'(bus.load), 32'd1);
        chk("wr_ign_sec_addr", 32'(bus.addrs), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("wr_ign_end_load", 32'(bus.load), 32'd0);
        chk("wr_ign_end_edit", 32'(bus.edit_active), 32'd0);
        nop(1);
        chk("wr_ign_idle_edit", 32'(bus.edit_active), 32'd0);
        chk("wr_ign_idle_load", 32'(bus.load), 32'd0);

        // Reset in the middle of WR_MIN
        step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_hr_data", 32'(bus.data_in), 32'd2);
        nop(1);
        chk("mid_min_load", 32'(bus.load), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_async_load",  32'(bus.load), 32'd0);
        chk("mid_async_addrs", 32'(bus.addrs), 32'd0);
        chk("mid_async_data",  32'(bus.data_in), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_load", 32'(bus.load), 32'd0);
        chk("mid_rst_edit", 32'(bus.edit_active), 32'd0);
        reset = 1'b1;
        load_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nop(1);
            load_seen = load_seen | bus.load;
        end
        chk("mid_no_resume", 32'(load_seen), 32'd0);
        chk("mid_idle_edit", 32'(bus.edit_active), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_commit("c_after_rst", 0, 0, 0);

        // Idle time in EDIT_HR
        step(1'b1, 1'b0, 1'b0);
        chk("to_enter", 32'(bus.edit_active), 32'd1);
        load_seen = 1'b0;
`ifdef CLK_SET_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            nop(1);
            load_seen = load_seen | bus.load;
        end
        chk("to_before", 32'(bus.edit_active), 32'd1);
        nop(1);
        load_seen = load_seen | bus.load;
        chk("to_edit",  32'(bus.edit_active), 32'd0);
        chk("to_field", 32'(bus.edit_field), 32'd0);
        nop(2);
        load_seen = load_seen | bus.load;
        chk("to_no_load", 32'(load_seen), 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            nop(1);
            load_seen = load_seen | bus.load;
        end
        chk("hold_edit",    32'(bus.edit_active), 32'd1);
        chk("hold_field",   32'(bus.edit_field), 32'd2);
        chk("hold_no_load", 32'(load_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
